aes128_encrypt_core: RTL and testbench

//  Iterative AES-128 (FIPS-197) encryption engine: one 128-bit plaintext block,
//  one 128-bit cipher key, one round per clock.

---
 rtl/aes128_encrypt_core_if.sv | 10 +
 rtl/aes128_encrypt_core.sv | 102 ++++++++++
 tb/tb_aes128_encrypt_core.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/aes128_encrypt_core_if.sv
// Block-level bus of the iterative AES-128 encryption core.
interface aes128_encrypt_core_if;
    logic [127:0] datain;
    logic [127:0] key;
    logic [127:0] dataout;
    logic         valid;

    modport master (output datain, output key, input dataout, input valid);
    modport slave  (input datain, input key, output dataout, output valid);
endinterface

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption: one round per clock, 11 cycles per block,
// free-running sample/compute/publish loop with on-the-fly key expansion.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    assign y = SBOX[a];
endmodule

module aes128_encrypt_core (
    input  logic                        clk,
    input  logic                        rst_n,
    aes128_encrypt_core_if.slave        bus
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [3:0]   rnd;
    logic [127:0] st, rk;
    logic [7:0]   rcon;
    logic [127:0] sb, sr, mc, rk_nxt;
    logic [31:0]  rot, sw, t;

    assign rot = {rk[23:0], rk[31:24]};

    for (genvar i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sbox (.a(st[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
    end
    for (genvar i = 0; i < 4; i++) begin : g_ksb
        aes_sbox u_sbox (.a(rot[31-8*i -: 8]), .y(sw[31-8*i -: 8]));
    end

    // Byte index 4*col+row; row r rotates left by r columns.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    end

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++)
            mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end

    always_comb begin
        t = sw ^ {rcon, 24'h0};
        rk_nxt[127:96] = rk[127:96] ^ t;
        rk_nxt[95:64]  = rk[95:64]  ^ rk_nxt[127:96];
        rk_nxt[63:32]  = rk[63:32]  ^ rk_nxt[95:64];
        rk_nxt[31:0]   = rk[31:0]   ^ rk_nxt[63:32];
    end

    // rcon reaches 8'h36 exactly when rnd==10, so the final round uses the register too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd         <= '0;
            st          <= '0;
            rk          <= '0;
            rcon        <= '0;
            bus.dataout <= '0;
            bus.valid   <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            if (rnd == 4'd0) begin
                st   <= bus.datain ^ bus.key;
                rk   <= bus.key;
                rcon <= 8'h01;
                rnd  <= 4'd1;
            end else if (rnd == 4'd10) begin
                bus.dataout <= sr ^ rk_nxt;
                bus.valid   <= 1'b1;
                rnd         <= 4'd0;
            end else begin
                st   <= mc ^ rk_nxt;
                rk   <= rk_nxt;
                rcon <= xtime(rcon);
                rnd  <= rnd + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Randomized bench for aes128_encrypt_core against a byte-level FIPS-197 model
// whose S-box is derived from the GF(2^8) inverse and affine map.
module tb_aes128_encrypt_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    aes128_encrypt_core_if bus ();

    aes128_encrypt_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] sbx [256];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %032h expected %032h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0] w [44][4];
        logic [7:0] s [16];
        logic [7:0] u [16];
        logic [7:0] tmp [4];
        logic [7:0] rc = 8'h01;
        logic [127:0] out;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = k[127-8*(4*i+j) -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                for (int j = 0; j < 4; j++) tmp[j] = sbx[w[i-1][(j+1)%4]];
                tmp[0] ^= rc;
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][j%4];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) u[4*c+row] = sbx[s[4*((c+row)%4)+row]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    if (r < 10)
                        s[4*c+row] = gmul(u[4*c+row], 8'h02) ^ gmul(u[4*c+(row+1)%4], 8'h03)
                                   ^ u[4*c+(row+2)%4] ^ u[4*c+(row+3)%4];
                    else
                        s[4*c+row] = u[4*c+row];
            for (int j = 0; j < 16; j++) s[j] ^= w[4*r + j/4][j%4];
        end
        for (int j = 0; j < 16; j++) out[127-8*j -: 8] = s[j];
        return out;
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbx[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    // Behavioural timing: after release, edges 0,11,22.. (mod 11 == 0) sample,
    // the 11th edge of each block publishes.
    int           ecnt = 0;
    logic [127:0] pend = '0;
    logic [127:0] exp_d = '0;
    logic         exp_v = 1'b0;

    always @(negedge rst_n) begin
        ecnt  = 0;
        exp_d = '0;
        exp_v = 1'b0;
        #1;
        chk("async_reset_dataout", bus.dataout, '0);
        chk("async_reset_valid", {127'b0, bus.valid}, '0);
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (ecnt == 0) pend = aes_enc(bus.datain, bus.key);
            exp_v = (ecnt == 10);
            if (exp_v) exp_d = pend;
            ecnt = (ecnt + 1) % 11;
        end
        #1;
        chk("valid", {127'b0, bus.valid}, {127'b0, exp_v});
        chk("dataout", bus.dataout, exp_d);
    end

    task automatic release_rst;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lit(input string name, input logic [127:0] pt, input logic [127:0] k,
                       input logic [127:0] exp);
        int found = 0;
        chk({name, "_model"}, aes_enc(pt, k), exp);
        @(negedge clk);
        rst_n = 1'b0;
        bus.datain = pt;
        bus.key = k;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #2;
            if (bus.valid) begin
                found = i;
                break;
            end
        end
        chk({name, "_latency"}, 128'(found), 128'd11);
        chk({name, "_dataout"}, bus.dataout, exp);
    endtask

    initial begin
        bus.datain = '0;
        bus.key = '0;
        repeat (3) @(negedge clk);
        chk("reset_dataout", bus.dataout, '0);
        chk("reset_valid", {127'b0, bus.valid}, '0);

        lit("vec_twoone", 128'h54776f204f6e65204e696e652054776f,
            128'h5468617473206d79204b756e67204675, 128'h29c3505f571420f6402299b31a02d73a);
        lit("fips_c1", 128'h00112233445566778899aabbccddeeff,
            128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        lit("fips_b", 128'h3243f6a8885a308d313198a2e0370734,
            128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32);

        // Input change mid-block: the scoreboard expects the old block to finish intact.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        bus.datain = {$urandom, $urandom, $urandom, $urandom};
        repeat (30) @(negedge clk);

        // Reset mid-block for 3 cycles, then 4 blocks of constant inputs.
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (46) @(negedge clk);

        // Randomized inputs changing at random points.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) bus.datain = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 5) == 0) bus.key = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 150) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        release_rst();
        repeat (12) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
